// File: rtl/jtopl_pkg.sv
// Shared constants for the OPL CPU write path: register map, control bit positions, update kinds.
// The OPL2 waveform registers are decoded only when JTOPL_OPL2_EN is defined.
package jtopl_pkg;

    localparam int HOLD_DEF = 24;

    localparam logic [7:0] REG_TEST   = 8'h01;
    localparam logic [7:0] REG_TIMA   = 8'h02;
    localparam logic [7:0] REG_TIMB   = 8'h03;
    localparam logic [7:0] REG_TCTL   = 8'h04;
    localparam logic [7:0] REG_CSM    = 8'h08;
    localparam logic [7:0] REG_MULT   = 8'h20;
    localparam logic [7:0] REG_KSL_TL = 8'h40;
    localparam logic [7:0] REG_AR_DR  = 8'h60;
    localparam logic [7:0] REG_SL_RR  = 8'h80;
    localparam logic [7:0] REG_FNUMLO = 8'hA0;
    localparam logic [7:0] REG_FNUMHI = 8'hB0;
    localparam logic [7:0] REG_RHY    = 8'hBD;
    localparam logic [7:0] REG_FBCON  = 8'hC0;
    localparam logic [7:0] REG_WAV    = 8'hE0;

    localparam int BD_AM      = 7;
    localparam int BD_VIB     = 6;
    localparam int BD_RHY     = 5;
    localparam int TC_RST     = 7;
    localparam int TC_MASKA   = 6;
    localparam int TC_MASKB   = 5;
    localparam int TC_LOADB   = 1;
    localparam int TC_LOADA   = 0;
    localparam int CSM_BIT    = 7;
    localparam int NSEL_BIT   = 6;
    localparam int WAV_EN_BIT = 5;

    // Enum value doubles as the bit index into the update-strobe vector.
    typedef enum logic [2:0] {
        UP_MULT   = 3'd0,
        UP_KSL_TL = 3'd1,
        UP_AR_DR  = 3'd2,
        UP_SL_RR  = 3'd3,
        UP_FNUMLO = 3'd4,
        UP_FNUMHI = 3'd5,
        UP_FBCON  = 3'd6,
        UP_WAV    = 3'd7
    } up_e;

    function automatic logic [7:0] up_onehot(input up_e k);
        return 8'd1 << k;
    endfunction

endpackage

// File: rtl/jtopl_wr_slot.sv
// Maps an operator offset (5 bits) or a channel number (low 4 bits) to group/subslot plus validity.
module jtopl_wr_slot
    import jtopl_pkg::*;
(
    input  logic [4:0] idx,
    input  logic       is_ch,
    output logic [1:0] group,
    output logic [2:0] sub,
    output logic       valid
);

    always_comb begin
        group = 2'd0;
        sub   = 3'd0;
        valid = 1'b0;
        if (is_ch) begin
            valid = 1'b1;
            case (idx[3:0])
                4'd0: begin group = 2'd0; sub = 3'd0; end
                4'd1: begin group = 2'd0; sub = 3'd1; end
                4'd2: begin group = 2'd0; sub = 3'd2; end
                4'd3: begin group = 2'd1; sub = 3'd0; end
                4'd4: begin group = 2'd1; sub = 3'd1; end
                4'd5: begin group = 2'd1; sub = 3'd2; end
                4'd6: begin group = 2'd2; sub = 3'd0; end
                4'd7: begin group = 2'd2; sub = 3'd1; end
                4'd8: begin group = 2'd2; sub = 3'd2; end
                default: valid = 1'b0;
            endcase
        end else begin
            group = idx[4:3];
            sub   = idx[2:0];
            valid = (idx[2:0] <= 3'd5) && (idx[4:3] <= 2'd2);
        end
    end

endmodule

// File: rtl/jtopl_wr_dec.sv
// CPU write decoder: address/data port writes -> held update strobes, slot selectors, global regs.
// Define JTOPL_OPL2_EN to decode 0x01 (wav_en) and 0xE0-0xF5 (up_wav).
module jtopl_wr_dec
    import jtopl_pkg::*;
#(
    parameter int HOLD = HOLD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic [7:0] cpu_din,
    input  logic       cpu_addr,
    input  logic       cpu_wr,
    output logic       write,
    output logic [7:0] din,
    output logic [1:0] sel_group,
    output logic [2:0] sel_sub,
    output logic       up_mult,
    output logic       up_ksl_tl,
    output logic       up_ar_dr,
    output logic       up_sl_rr,
    output logic       up_fnumlo,
    output logic       up_fnumhi,
    output logic       up_fbcon,
    output logic       up_wav,
    output logic       busy,
    output logic       rhy_en,
    output logic [4:0] rhy_kon,
    output logic       am_dep,
    output logic       vib_dep,
    output logic       csm,
    output logic       note_sel,
    output logic [7:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       mask_A,
    output logic       mask_B,
    output logic       clr_flags,
    output logic       wav_en
);

    localparam int CW = $clog2(HOLD + 1);

    // cpu_wr is a one-clk strobe with no back-pressure: every access is accepted on the clk it is
    // sampled; cpu_addr=0 targets the address port, cpu_addr=1 the data port.
    logic [7:0]    sel_reg;
    logic [7:0]    up_vec;
    logic [CW-1:0] cnt;
    logic          wav_en_r;

    logic       is_upd, is_ch, slot_valid, dec_valid;
    up_e        kind;
    logic [1:0] slot_group;
    logic [2:0] slot_sub;

    always_comb begin
        is_upd = 1'b0;
        is_ch  = 1'b0;
        kind   = UP_MULT;
        case (sel_reg[7:4])
            REG_FNUMLO[7:4]: begin is_upd = 1'b1; is_ch = 1'b1; kind = UP_FNUMLO; end
            REG_FNUMHI[7:4]: begin is_upd = 1'b1; is_ch = 1'b1; kind = UP_FNUMHI; end
            REG_FBCON[7:4]:  begin is_upd = 1'b1; is_ch = 1'b1; kind = UP_FBCON;  end
            default: begin
                case (sel_reg[7:5])
                    REG_MULT[7:5]:   begin is_upd = 1'b1; kind = UP_MULT;   end
                    REG_KSL_TL[7:5]: begin is_upd = 1'b1; kind = UP_KSL_TL; end
                    REG_AR_DR[7:5]:  begin is_upd = 1'b1; kind = UP_AR_DR;  end
                    REG_SL_RR[7:5]:  begin is_upd = 1'b1; kind = UP_SL_RR;  end
`ifdef JTOPL_OPL2_EN
                    REG_WAV[7:5]:    begin is_upd = 1'b1; kind = UP_WAV;    end
`endif
                    default: ;
                endcase
            end
        endcase
    end

    jtopl_wr_slot u_slot (
        .idx   (sel_reg[4:0]),
        .is_ch (is_ch),
        .group (slot_group),
        .sub   (slot_sub),
        .valid (slot_valid)
    );

    assign dec_valid = is_upd && slot_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_reg   <= '0;
            up_vec    <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            write     <= 1'b0;
            din       <= '0;
            sel_group <= '0;
            sel_sub   <= '0;
            rhy_en    <= 1'b0;
            rhy_kon   <= '0;
            am_dep    <= 1'b0;
            vib_dep   <= 1'b0;
            csm       <= 1'b0;
            note_sel  <= 1'b0;
            value_A   <= '0;
            value_B   <= '0;
            load_A    <= 1'b0;
            load_B    <= 1'b0;
            mask_A    <= 1'b0;
            mask_B    <= 1'b0;
            clr_flags <= 1'b0;
            wav_en_r  <= 1'b0;
        end else begin
            write     <= 1'b0;
            clr_flags <= 1'b0;
            if (cpu_wr && !cpu_addr) sel_reg <= cpu_din;
            if (cpu_wr && cpu_addr) begin
                din   <= cpu_din;
                write <= 1'b1;
                case (sel_reg)
`ifdef JTOPL_OPL2_EN
                    REG_TEST: wav_en_r <= cpu_din[WAV_EN_BIT];
`endif
                    REG_TIMA: value_A <= cpu_din;
                    REG_TIMB: value_B <= cpu_din;
                    REG_TCTL: begin
                        if (cpu_din[TC_RST]) begin
                            clr_flags <= 1'b1;
                        end else begin
                            load_A <= cpu_din[TC_LOADA];
                            load_B <= cpu_din[TC_LOADB];
                            mask_A <= cpu_din[TC_MASKA];
                            mask_B <= cpu_din[TC_MASKB];
                        end
                    end
                    REG_CSM: begin
                        csm      <= cpu_din[CSM_BIT];
                        note_sel <= cpu_din[NSEL_BIT];
                    end
                    REG_RHY: begin
                        am_dep  <= cpu_din[BD_AM];
                        vib_dep <= cpu_din[BD_VIB];
                        rhy_en  <= cpu_din[BD_RHY];
                        rhy_kon <= cpu_din[4:0];
                    end
                    default: ;
                endcase
            end
            // A new valid update takes priority over the hold countdown on the same clk.
            if (cpu_wr && cpu_addr && dec_valid) begin
                up_vec    <= up_onehot(kind);
                busy      <= 1'b1;
                cnt       <= CW'(HOLD);
                sel_group <= slot_group;
                sel_sub   <= slot_sub;
            end else if (cen && cnt != '0) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    up_vec <= '0;
                    busy   <= 1'b0;
                end
            end
        end
    end

    assign up_mult   = up_vec[UP_MULT];
    assign up_ksl_tl = up_vec[UP_KSL_TL];
    assign up_ar_dr  = up_vec[UP_AR_DR];
    assign up_sl_rr  = up_vec[UP_SL_RR];
    assign up_fnumlo = up_vec[UP_FNUMLO];
    assign up_fnumhi = up_vec[UP_FNUMHI];
    assign up_fbcon  = up_vec[UP_FBCON];
    assign up_wav    = up_vec[UP_WAV];
    assign wav_en    = wav_en_r;

endmodule

// File: tb/tb_jtopl_wr_dec.sv
// Bench for jtopl_wr_dec: register-map vector table plus hold/replace/reset sequences.
module tb_jtopl_wr_dec;

  localparam int HOLD = 24;
  localparam int SW = 53;
`ifdef JTOPL_OPL2_EN
  localparam bit OPL2 = 1'b1;
`else
  localparam bit OPL2 = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen = 1'b0;
  logic [7:0] cpu_din = '0;
  logic cpu_addr = 1'b0;
  logic cpu_wr = 1'b0;
  logic write, busy, clr_flags, wav_en;
  logic [7:0] din, value_A, value_B;
  logic [1:0] sel_group;
  logic [2:0] sel_sub;
  logic up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_fnumlo, up_fnumhi, up_fbcon, up_wav;
  logic rhy_en, am_dep, vib_dep, csm, note_sel, load_A, load_B, mask_A, mask_B;
  logic [4:0] rhy_kon;

  int n_checks = 0;
  int n_pass = 0;

  jtopl_wr_dec #(.HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .cen(cen), .cpu_din(cpu_din), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr),
    .write(write), .din(din), .sel_group(sel_group), .sel_sub(sel_sub),
    .up_mult(up_mult), .up_ksl_tl(up_ksl_tl), .up_ar_dr(up_ar_dr), .up_sl_rr(up_sl_rr),
    .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi), .up_fbcon(up_fbcon), .up_wav(up_wav),
    .busy(busy), .rhy_en(rhy_en), .rhy_kon(rhy_kon), .am_dep(am_dep), .vib_dep(vib_dep),
    .csm(csm), .note_sel(note_sel), .value_A(value_A), .value_B(value_B),
    .load_A(load_A), .load_B(load_B), .mask_A(mask_A), .mask_B(mask_B),
    .clr_flags(clr_flags), .wav_en(wav_en)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] up;
    logic [1:0] g;
    logic [2:0] s;
    logic       clr;
    logic [7:0] rhy;
    logic [7:0] ta;
    logic [7:0] tb;
    logic [3:0] t;
    logic [1:0] c;
    logic       w;
  } vec_t;

  vec_t tbl[$];
  logic [SW-1:0] exp_q[$];

  function automatic logic [7:0] up_now();
    return {up_wav, up_fbcon, up_fnumhi, up_fnumlo, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult};
  endfunction

  function automatic logic [SW-1:0] dut_snap();
    return {up_now(), busy, sel_group, sel_sub, din, am_dep, vib_dep, rhy_en, rhy_kon,
            value_A, value_B, load_A, load_B, mask_A, mask_B, csm, note_sel, wav_en};
  endfunction

  function automatic logic [SW-1:0] exp_snap(input vec_t v);
    return {v.up, |v.up, v.g, v.s, v.d, v.rhy, v.ta, v.tb, v.t, v.c, v.w};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic [7:0] a, d, up, input logic [1:0] g, input logic [2:0] s,
                     input logic clr, input logic [7:0] rhy, ta, tb, input logic [3:0] t,
                     input logic [1:0] c, input logic w);
    vec_t v;
    v.a = a; v.d = d; v.up = up; v.g = g; v.s = s; v.clr = clr;
    v.rhy = rhy; v.ta = ta; v.tb = tb; v.t = t; v.c = c; v.w = w;
    tbl.push_back(v);
  endtask

  // driver tasks
  task automatic cpu_write(input logic a, input logic [7:0] d, input logic c);
    @(negedge clk);
    cpu_wr = 1'b1; cpu_addr = a; cpu_din = d; cen = c;
    @(posedge clk); #1;
    cpu_wr = 1'b0; cen = 1'b0;
  endtask

  task automatic tick_cen();
    @(negedge clk);
    cen = 1'b1;
    @(posedge clk); #1;
    cen = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < HOLD + 4 && busy; i++) tick_cen();
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'(dut_snap()), 64'd0);
    check("reset_write_clr", {62'd0, write, clr_flags}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    //    addr   data   up     g  s  clr rhy    ta     tb     t     c  w
    add(8'h35, 8'h5A, 8'h01, 2, 5, 0, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0);
    add(8'h26, 8'hFF, 8'h00, 2, 5, 0, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0);
    add(8'h48, 8'h11, 8'h02, 1, 0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0);
    add(8'h6C, 8'h22, 8'h04, 1, 4, 0, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0);
    add(8'h92, 8'h33, 8'h08, 2, 2, 0, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0);
    add(8'h98, 8'h44, 8'h00, 2, 2, 0, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0);
    add(8'hA7, 8'h55, 8'h10, 2, 1, 0, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0);
    add(8'hB3, 8'h66, 8'h20, 1, 0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0);
    add(8'hC8, 8'h77, 8'h40, 2, 2, 0, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0);
    add(8'hA9, 8'h88, 8'h00, 2, 2, 0, 8'h00, 8'h00, 8'h00, 4'h0, 0, 0);
    add(8'hBD, 8'hFF, 8'h00, 2, 2, 0, 8'hFF, 8'h00, 8'h00, 4'h0, 0, 0);
    add(8'h02, 8'hC3, 8'h00, 2, 2, 0, 8'hFF, 8'hC3, 8'h00, 4'h0, 0, 0);
    add(8'h03, 8'h3C, 8'h00, 2, 2, 0, 8'hFF, 8'hC3, 8'h3C, 4'h0, 0, 0);
    add(8'h04, 8'h63, 8'h00, 2, 2, 0, 8'hFF, 8'hC3, 8'h3C, 4'hF, 0, 0);
    add(8'h04, 8'h80, 8'h00, 2, 2, 1, 8'hFF, 8'hC3, 8'h3C, 4'hF, 0, 0);
    add(8'h08, 8'hC0, 8'h00, 2, 2, 0, 8'hFF, 8'hC3, 8'h3C, 4'hF, 3, 0);
    add(8'h04, 8'h00, 8'h00, 2, 2, 0, 8'hFF, 8'hC3, 8'h3C, 4'h0, 3, 0);
    if (OPL2) add(8'hE3, 8'h02, 8'h80, 0, 3, 0, 8'hFF, 8'hC3, 8'h3C, 4'h0, 3, 0);
    else      add(8'hE3, 8'h02, 8'h00, 2, 2, 0, 8'hFF, 8'hC3, 8'h3C, 4'h0, 3, 0);
    if (OPL2) add(8'h01, 8'h20, 8'h00, 0, 3, 0, 8'hFF, 8'hC3, 8'h3C, 4'h0, 3, 1);
    else      add(8'h01, 8'h20, 8'h00, 2, 2, 0, 8'hFF, 8'hC3, 8'h3C, 4'h0, 3, 0);
    add(8'h50, 8'h01, 8'h02, 2, 0, 0, 8'hFF, 8'hC3, 8'h3C, 4'h0, 3, OPL2);
    add(8'hBD, 8'h00, 8'h00, 2, 0, 0, 8'h00, 8'hC3, 8'h3C, 4'h0, 3, OPL2);
    add(8'h07, 8'hAA, 8'h00, 2, 0, 0, 8'h00, 8'hC3, 8'h3C, 4'h0, 3, OPL2);

    foreach (tbl[i]) begin
      logic [SW-1:0] e;
      cpu_write(1'b0, tbl[i].a, 1'b0);
      exp_q.push_back(exp_snap(tbl[i]));
      cpu_write(1'b1, tbl[i].d, 1'b0);
      e = exp_q.pop_front();
      check($sformatf("row%0d_a%h_outputs", i, tbl[i].a), 64'(dut_snap()), 64'(e));
      check($sformatf("row%0d_a%h_write_clr", i, tbl[i].a), {62'd0, write, clr_flags},
            {62'd0, 1'b1, tbl[i].clr});
      idle();
      check($sformatf("row%0d_pulse_end", i), {62'd0, write, clr_flags}, 64'd0);
      drain();
      check($sformatf("row%0d_drained", i), {55'd0, busy, up_now()}, 64'd0);
    end

    // hold length, with cen on the same clk as the data write and gaps between cen ticks
    cpu_write(1'b0, 8'h35, 1'b0);
    cpu_write(1'b1, 8'h5A, 1'b1);
    check("hold_start", {51'd0, up_now(), sel_group, sel_sub}, {51'd0, 8'h01, 2'd2, 3'd5});
    for (int i = 0; i < HOLD - 1; i++) begin
      tick_cen();
      idle();
    end
    check("hold_23_ticks", {55'd0, busy, up_now()}, {55'd0, 1'b1, 8'h01});
    tick_cen();
    check("hold_24_ticks", {55'd0, busy, up_now()}, 64'd0);

    // replacement during hold restarts the counter
    cpu_write(1'b0, 8'hB8, 1'b0);
    cpu_write(1'b1, 8'h31, 1'b0);
    check("repl_first", {51'd0, up_now(), sel_group, sel_sub}, {51'd0, 8'h20, 2'd2, 3'd2});
    repeat (10) tick_cen();
    cpu_write(1'b0, 8'hA0, 1'b0);
    cpu_write(1'b1, 8'h12, 1'b0);
    check("repl_second", {51'd0, up_now(), sel_group, sel_sub}, {51'd0, 8'h10, 2'd0, 3'd0});
    repeat (HOLD - 1) tick_cen();
    check("repl_reload", {55'd0, busy, up_now()}, {55'd0, 1'b1, 8'h10});
    tick_cen();
    check("repl_expire", {55'd0, busy, up_now()}, 64'd0);

    // asynchronous reset mid-hold
    cpu_write(1'b0, 8'h35, 1'b0);
    cpu_write(1'b1, 8'h5A, 1'b0);
    repeat (5) tick_cen();
    check("rst_pre", {63'd0, busy}, 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_hold", 64'(dut_snap()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cpu_write(1'b1, 8'h77, 1'b0);
    check("rst_sel_reg_cleared", {52'd0, busy, up_now(), din}, {52'd0, 1'b0, 8'h00, 8'h77});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
